// File: rtl/dip_scan_ctrl.sv
// Scanner for a 74HC165-style PISO switch chain: load/shift sequencing on a divided tick,
// serial-to-parallel capture, and frame-to-frame debounce of the published word.
module dip_scan_ctrl #(
   parameter int WIDTH     = 16,
   parameter int CLK_DIV   = 4,
   parameter int DEBOUNCE  = 3,
   parameter int GAP       = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             data,
   output logic             latch_n,
   output logic             sclk,
   output logic [WIDTH-1:0] out,
   output logic             valid,
   output logic             changed
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int BW = $clog2(WIDTH);
   localparam int GW = $clog2(GAP + 2);
   localparam int CW = $clog2(DEBOUNCE + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SAMPLE, S_CLOCK, S_UPDATE, S_GAP} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc;
   logic             tick;
   logic [BW-1:0]    bit_q, bit_d, idx;
   logic [GW-1:0]    gap_q, gap_d;
   logic [WIDTH-1:0] shadow, prev;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             publish;

   assign tick = (presc == PW'(CLK_DIV - 1));
   assign idx  = (MSB_FIRST != 0) ? (BW'(WIDTH - 1) - bit_q) : bit_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) presc <= '0;
      else        presc <= tick ? '0 : presc + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE:   if (tick && en) state_d = S_LOAD;
         S_LOAD:   if (tick) begin
                      state_d = S_SAMPLE;
                      bit_d   = '0;
                   end
         S_SAMPLE: if (tick) state_d = (bit_q == BW'(WIDTH - 1)) ? S_UPDATE : S_CLOCK;
         S_CLOCK:  if (tick) begin
                      state_d = S_SAMPLE;
                      bit_d   = bit_q + 1'b1;
                   end
         S_UPDATE: begin
                      state_d = (GAP > 0) ? S_GAP : S_IDLE;
                      gap_d   = '0;
                   end
         S_GAP:    if (tick) begin
                      if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
                      else                       gap_d   = gap_q + 1'b1;
                   end
         default:  state_d = S_IDLE;
      endcase
   end

   // Saturating run length of identical frames, evaluated against the frame just captured.
   always_comb begin
      cnt_nx = CW'(1);
      if (shadow == prev) cnt_nx = (cnt >= CW'(DEBOUNCE)) ? CW'(DEBOUNCE) : cnt + 1'b1;
      publish = (cnt_nx >= CW'(DEBOUNCE)) && (shadow != out);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         gap_q   <= '0;
         latch_n <= 1'b1;
         sclk    <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         // Strobes decode the next state so they switch with the state register, glitch-free.
         latch_n <= (state_d != S_LOAD);
         sclk    <= (state_d == S_CLOCK);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow  <= '0;
         prev    <= '0;
         cnt     <= '0;
         out     <= '0;
         valid   <= 1'b0;
         changed <= 1'b0;
      end else begin
         valid   <= 1'b0;
         changed <= 1'b0;
         if (state_q == S_SAMPLE && tick) shadow[idx] <= data;
         if (state_q == S_UPDATE) begin
            prev    <= shadow;
            cnt     <= cnt_nx;
            valid   <= 1'b1;
            changed <= publish;
            if (publish) out <= shadow;
         end
      end
   end

endmodule

// File: tb/tb_dip_scan_ctrl.sv
// Directed bench: two scanners (MSB-first/DEBOUNCE=2 and LSB-first/DEBOUNCE=3) each driven by a shift-register chain model.
module tb_dip_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, en;
   logic [7:0] chain_a, chain_b;
   logic [7:0] sr_a = 8'h00, sr_b = 8'h00;
   logic       a_data, a_latch_n, a_sclk, a_valid, a_changed;
   logic       b_data, b_latch_n, b_sclk, b_valid, b_changed;
   logic [7:0] a_out, b_out;

   int  n_vec = 0, n_bad = 0;
   int  b_sclk_cnt = 0, b_chg_cnt = 0, ovl = 0;
   longint lf_t = 0, lf_per = 0, lf_per_prev = 0;

   always #5 clk = ~clk;

   dip_scan_ctrl #(.WIDTH(8), .CLK_DIV(2), .DEBOUNCE(2), .GAP(2), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .data(a_data), .latch_n(a_latch_n), .sclk(a_sclk),
      .out(a_out), .valid(a_valid), .changed(a_changed));

   dip_scan_ctrl #(.WIDTH(8), .CLK_DIV(2), .DEBOUNCE(3), .GAP(2), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .data(b_data), .latch_n(b_latch_n), .sclk(b_sclk),
      .out(b_out), .valid(b_valid), .changed(b_changed));

   // 74HC165 model: parallel load while latch_n low, Q7 first, shift on sclk rise.
   always @(negedge a_latch_n or posedge a_sclk)
      if (!a_latch_n) sr_a <= chain_a; else sr_a <= {sr_a[6:0], 1'b0};
   always @(negedge b_latch_n or posedge b_sclk)
      if (!b_latch_n) sr_b <= chain_b; else sr_b <= {sr_b[6:0], 1'b0};
   assign a_data = sr_a[7];
   assign b_data = sr_b[7];

   always @(posedge b_sclk) b_sclk_cnt <= b_sclk_cnt + 1;
   always @(negedge a_latch_n) begin
      lf_per      <= longint'($time) - lf_t;
      lf_t        <= longint'($time);
      lf_per_prev <= lf_per;
   end
   always @(negedge clk) begin
      if (b_changed) b_chg_cnt <= b_chg_cnt + 1;
      if (rst_n && ((!a_latch_n && a_sclk) || (!b_latch_n && b_sclk))) ovl <= ovl + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_vld(input string tag);
      int i;
      for (i = 0; i < 400; i++) begin
         @(negedge clk);
         if (a_valid) break;
      end
      chk(tag, 64'(i < 400), 1);
   endtask

   task automatic wait_lat(input int bound, input string tag);
      int i;
      for (i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!a_latch_n) break;
      end
      chk(tag, 64'(i < bound), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lo, s0, c0, nlat, i;
      rst_n = 1'b0; en = 1'b1; chain_a = 8'hA5; chain_b = 8'h01;
      repeat (5) @(negedge clk);
      chk("rst_latch_n", a_latch_n, 1);
      chk("rst_sclk",    a_sclk, 0);
      chk("rst_out_a",   a_out, 8'h00);
      chk("rst_out_b",   b_out, 8'h00);
      chk("rst_valid",   a_valid | b_valid, 0);
      chk("rst_changed", a_changed | b_changed, 0);

      rst_n = 1'b1;
      wait_lat(4, "first_load");
      lo = 0;
      while (!b_latch_n && lo < 10) begin
         lo++;
         @(negedge clk);
      end
      chk("latch_width", lo, 2);
      s0 = b_sclk_cnt;

      wait_vld("f1_valid");
      chk("f1_b_valid",   b_valid, 1);
      chk("f1_changed",   a_changed, 0);
      chk("f1_out",       a_out, 8'h00);
      chk("sclk_edges",   b_sclk_cnt - s0, 7);

      wait_vld("f2_valid");
      chk("f2_out",       a_out, 8'hA5);
      chk("f2_changed",   a_changed, 1);
      chk("f2_b_out",     b_out, 8'h00);
      chk("f2_b_changed", b_changed, 0);

      wait_vld("f3_valid");
      chk("f3_out",       a_out, 8'hA5);
      chk("f3_changed",   a_changed, 0);
      chk("bitorder_out", b_out, 8'h80);
      chk("b_changed",    b_changed, 1);
      chk("period_const", lf_per, lf_per_prev);

      // Drop en partway through the shift phase; the frame must still finish.
      wait_lat(60, "en_frame_start");
      repeat (10) @(negedge clk);
      en = 1'b0;
      wait_vld("en_off_valid");
      nlat = 0;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!a_latch_n || !b_latch_n) nlat++;
      end
      chk("en_off_idle", nlat, 0);
      en = 1'b1;
      wait_lat(8, "en_resume");

      // Async reset while the chain is being clocked.
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (a_sclk) break;
      end
      chk("sclk_seen", 64'(i < 100), 1);
      chk("pre_rst_out", a_out, 8'hA5);
      rst_n = 1'b0;
      #1;
      chk("midrst_out",  a_out, 8'h00);
      chk("midrst_sclk", a_sclk, 0);
      chk("midrst_lat",  a_latch_n, 1);
      chain_b = 8'hF0;   // reads back as 0x0F LSB-first
      @(negedge clk);
      rst_n = 1'b1;

      wait_vld("r1_valid");
      chk("r1_out",   a_out, 8'h00);
      chk("bn1_out",  b_out, 8'h00);
      chain_b = 8'h70;   // 0x0E
      c0 = b_chg_cnt;
      wait_vld("r2_valid");
      chk("r2_out",     a_out, 8'hA5);
      chk("r2_changed", a_changed, 1);
      chk("bn2_out",    b_out, 8'h00);
      chain_b = 8'hF0;
      wait_vld("bn3_valid");
      chk("bn3_out",  b_out, 8'h00);
      wait_vld("bn4_valid");
      chk("bn4_out",  b_out, 8'h00);
      wait_vld("bn5_valid");
      chk("bn5_out",     b_out, 8'h0F);
      chk("bn5_changed", b_changed, 1);
      @(negedge clk);
      chk("bn_chg_once", b_chg_cnt - c0, 1);
      chk("no_overlap",  ovl, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
